sd_rrarb_iofull: RTL

// - N-input round-robin arbiter that shares one fully registered srdy/drdy output stage (2-entry hold buffer).
// - Sits in front of a shared downstream resource. Merges requester streams onto one timing-closed channel.
// - p_srdy, p_data and p_grant come from flops. Each c_drdy[i] is ready_q AND'd with the arbiter select.

---
 rtl/sd_rrarb_iofull.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sd_rrarb_iofull.sv
`default_nettype none
// ============================================================================
// Module   : sd_rrarb_iofull
// Purpose  : N-input round-robin arbiter merging requester streams onto one
//            fully registered srdy/drdy output stage (2-entry hold buffer).
//            p_srdy/p_data/p_grant are flop outputs; c_drdy is the registered
//            ready qualified by the arbiter select.
// Options  : SD_RRARB_PKT_LOCK_EN - adds c_eop and holds the grant on one
//            port from its first non-eop beat through its eop beat.
// Revision : 1.0 - initial release
// ============================================================================
module sd_rrarb_iofull #(
  parameter int INPUTS = 4,
  parameter int WIDTH  = 8,
  parameter int GW     = $clog2(INPUTS)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [INPUTS-1:0]       c_srdy,
  output logic [INPUTS-1:0]       c_drdy,
  input  logic [INPUTS*WIDTH-1:0] c_data,
`ifdef SD_RRARB_PKT_LOCK_EN
  input  logic [INPUTS-1:0]       c_eop,
`endif
  output logic                    p_srdy,
  input  logic                    p_drdy,
  output logic [WIDTH-1:0]        p_data,
  output logic [GW-1:0]           p_grant
);

  // Buffer occupancy states
  localparam logic [1:0] S_E  = 2'd0;
  localparam logic [1:0] S_H1 = 2'd1;
  localparam logic [1:0] S_H2 = 2'd2;

  logic [1:0]       r_cnt;
  logic             r_ready;
  logic             r_psrdy;
  logic [GW-1:0]    r_last_ptr;
  logic [WIDTH-1:0] r_hd_data;
  logic [GW-1:0]    r_hd_grant;
  logic [WIDTH-1:0] r_tl_data;
  logic [GW-1:0]    r_tl_grant;

  logic             w_any;
  logic [GW-1:0]    w_rr_sel;
  logic [GW-1:0]    w_sel;
  logic             w_sel_vld;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_cnt_nxt;
  logic [WIDTH-1:0] w_in_data;

`ifdef SD_RRARB_PKT_LOCK_EN
  logic             r_locked;
  logic [GW-1:0]    r_lock_port;
`endif

  // Round-robin search: first requester strictly after last_ptr, wrapping.
  // Walking the distance downward lets the nearest requester win last.
  always_comb begin
    w_any    = 1'b0;
    w_rr_sel = r_last_ptr;
    for (int k = INPUTS; k >= 1; k--) begin
      int idx;
      idx = (int'(r_last_ptr) + k) % INPUTS;
      if (c_srdy[idx]) begin
        w_any    = 1'b1;
        w_rr_sel = GW'(idx);
      end
    end
  end

`ifdef SD_RRARB_PKT_LOCK_EN
  // A locked packet owns the channel even while its producer idles
  assign w_sel     = r_locked ? r_lock_port : w_rr_sel;
  assign w_sel_vld = r_locked | w_any;
`else
  assign w_sel     = w_rr_sel;
  assign w_sel_vld = w_any;
`endif

  assign c_drdy    = (w_sel_vld && r_ready) ? ({{(INPUTS-1){1'b0}}, 1'b1} << w_sel)
                                            : {INPUTS{1'b0}};
  assign w_push    = |(c_srdy & c_drdy);
  assign w_pop     = r_psrdy & p_drdy;
  assign w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
  assign w_in_data = c_data[w_sel*WIDTH +: WIDTH];

  assign p_srdy  = r_psrdy;
  assign p_data  = r_hd_data;
  assign p_grant = r_hd_grant;

  // Occupancy, registered ready/valid and the two-entry head/tail storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= S_E;
      r_ready    <= 1'b0;
      r_psrdy    <= 1'b0;
      r_hd_data  <= '0;
      r_hd_grant <= '0;
      r_tl_data  <= '0;
      r_tl_grant <= '0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_ready <= (w_cnt_nxt < 2'd2);
      r_psrdy <= (w_cnt_nxt != S_E);
      case (r_cnt)
        S_E: begin
          if (w_push) begin
            r_hd_data  <= w_in_data;
            r_hd_grant <= w_sel;
          end
        end
        S_H1: begin
          if (w_push && w_pop) begin
            r_hd_data  <= w_in_data;
            r_hd_grant <= w_sel;
          end else if (w_push) begin
            r_tl_data  <= w_in_data;
            r_tl_grant <= w_sel;
          end
        end
        S_H2: begin
          if (w_pop) begin
            r_hd_data  <= r_tl_data;
            r_hd_grant <= r_tl_grant;
          end
        end
        default: ;
      endcase
    end
  end

  // Round-robin pointer (and packet lock) advance on accepted beats
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_ptr  <= GW'(INPUTS - 1);
`ifdef SD_RRARB_PKT_LOCK_EN
      r_locked    <= 1'b0;
      r_lock_port <= '0;
`endif
    end else if (w_push) begin
`ifdef SD_RRARB_PKT_LOCK_EN
      if (c_eop[w_sel]) begin
        r_locked   <= 1'b0;
        r_last_ptr <= w_sel;
      end else begin
        r_locked    <= 1'b1;
        r_lock_port <= w_sel;
      end
`else
      r_last_ptr <= w_sel;
`endif
    end
  end

endmodule
`default_nettype wire
